// File: rtl/ramp_pattern_generator_if.sv
// Control and sample bundle for ramp_pattern_generator.
//   master: drives enable, sync_restart, mode, step, lower_limit and upper_limit;
//           receives data_out, data_valid, direction, wrap_pulse and cfg_error.
//   slave:  the generator side of the same signals.
interface ramp_pattern_generator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
);
  logic                  enable;
  logic                  sync_restart;
  logic [1:0]            mode;
  logic [STEP_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0] lower_limit;
  logic [DATA_WIDTH-1:0] upper_limit;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  direction;
  logic                  wrap_pulse;
  logic                  cfg_error;

  modport master (
    output enable, sync_restart, mode, step, lower_limit, upper_limit,
    input  data_out, data_valid, direction, wrap_pulse, cfg_error
  );

  modport slave (
    input  enable, sync_restart, mode, step, lower_limit, upper_limit,
    output data_out, data_valid, direction, wrap_pulse, cfg_error
  );
endinterface

// File: rtl/ramp_pattern_generator.sv
// Registered ramp pattern source: sawtooth up, triangle, constant or
// sawtooth down between programmable limits with a programmable step.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of ramp_pattern_generator_if (controls in, samples out)
//
// state | meaning
// IDLE  | waiting for enable; start value and mode are taken on exit
// UP    | ascending (sawtooth up, or rising half of triangle)
// DOWN  | descending (sawtooth down, or falling half of triangle)
// HOLD  | constant mode, lower_limit every enabled cycle
module ramp_pattern_generator #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  ramp_pattern_generator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [1:0] MODE_SAW_UP   = 2'b00;
  localparam logic [1:0] MODE_TRIANGLE = 2'b01;
  localparam logic [1:0] MODE_CONST    = 2'b10;
  localparam logic [1:0] MODE_SAW_DN   = 2'b11;

  // One guard bit above the wider operand, so sums never overflow silently.
  localparam int AW = ((STEP_WIDTH > DATA_WIDTH) ? STEP_WIDTH : DATA_WIDTH) + 1;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  direction_q, direction_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic                  cfg_error_q, cfg_error_d;

  logic [AW-1:0] data_x, step_x, lo_x, hi_x, sum_x, diff_x, lo_step_x;
  logic          lim_bad, hold_step;

  assign data_x    = AW'(data_out_q);
  assign step_x    = AW'(bus.step);
  assign lo_x      = AW'(bus.lower_limit);
  assign hi_x      = AW'(bus.upper_limit);
  assign sum_x     = data_x + step_x;
  assign diff_x    = data_x - step_x;
  assign lo_step_x = lo_x + step_x;

  // Invalid limits block the computation on the same edge the flag is raised,
  // so no sample is ever produced from an inverted range.
  assign lim_bad   = bus.lower_limit > bus.upper_limit;
  // A zero step repeats the sample unless a limit change left it out of range.
  assign hold_step = (bus.step == '0) && (data_x >= lo_x) && (data_x <= hi_x);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    direction_d  = direction_q;
    wrap_pulse_d = 1'b0;
    cfg_error_d  = lim_bad;

    if (bus.sync_restart) begin
      state_d = IDLE;
    end else if (!lim_bad && bus.enable) begin
      data_valid_d = 1'b1;
      case (state_q)
        IDLE: begin
          mode_d = bus.mode;
          case (bus.mode)
            MODE_SAW_DN: begin
              data_out_d  = bus.upper_limit;
              direction_d = 1'b0;
              state_d     = DOWN;
            end
            MODE_CONST: begin
              data_out_d  = bus.lower_limit;
              direction_d = 1'b1;
              state_d     = HOLD;
            end
            default: begin
              data_out_d  = bus.lower_limit;
              direction_d = 1'b1;
              state_d     = UP;
            end
          endcase
        end
        UP: begin
          if (!hold_step) begin
            if (mode_q == MODE_TRIANGLE) begin
              if (sum_x < hi_x) begin
                data_out_d = sum_x[DATA_WIDTH-1:0];
              end else begin
                data_out_d  = bus.upper_limit;
                direction_d = 1'b0;
                state_d     = DOWN;
              end
            end else begin
              if (sum_x <= hi_x) begin
                data_out_d = sum_x[DATA_WIDTH-1:0];
              end else begin
                data_out_d   = bus.lower_limit;
                wrap_pulse_d = 1'b1;
              end
            end
          end
        end
        DOWN: begin
          if (!hold_step) begin
            if (mode_q == MODE_TRIANGLE) begin
              if ((data_x >= lo_step_x) && (diff_x > lo_x)) begin
                data_out_d = diff_x[DATA_WIDTH-1:0];
              end else begin
                data_out_d   = bus.lower_limit;
                direction_d  = 1'b1;
                state_d      = UP;
                wrap_pulse_d = 1'b1;
              end
            end else begin
              if (data_x >= lo_step_x) begin
                data_out_d = diff_x[DATA_WIDTH-1:0];
              end else begin
                data_out_d   = bus.upper_limit;
                wrap_pulse_d = 1'b1;
              end
            end
          end
        end
        HOLD: begin
          data_out_d = bus.lower_limit;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_SAW_UP;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      direction_q  <= 1'b1;
      wrap_pulse_q <= 1'b0;
      cfg_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      direction_q  <= direction_d;
      wrap_pulse_q <= wrap_pulse_d;
      cfg_error_q  <= cfg_error_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.direction  = direction_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_ramp_pattern_generator.sv
// Self-checking bench for ramp_pattern_generator: table of ramp cases whose
// expected samples are queued and compared as valid samples appear, plus
// hand-written sequences for enable gaps, restart, zero step, config error,
// limit clamping and asynchronous reset.
module tb_ramp_pattern_generator;
  localparam int DW = 7;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset;

  ramp_pattern_generator_if #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) bus ();

  ramp_pattern_generator #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          wrap;
    logic          dir;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int         step;
    int         lo;
    int         hi;
    int         n;
  } case_t;

  exp_t  sb[$];
  exp_t  period[$];
  case_t cases[6];
  int    checks = 0;
  int    errors = 0;

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input logic w, input logic dir);
    exp_t e;
    e.data = DW'(d);
    e.wrap = w;
    e.dir  = dir;
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit later, and score any valid sample.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.data_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: actual data=%0d required no sample", bus.data_out);
      end else begin
        e = sb.pop_front();
        if (bus.data_out !== e.data || bus.wrap_pulse !== e.wrap || bus.direction !== e.dir) begin
          errors++;
          $display("FAIL sample: actual data=%0d wrap=%0b dir=%0b required data=%0d wrap=%0b dir=%0b",
                   bus.data_out, bus.wrap_pulse, bus.direction, e.data, e.wrap, e.dir);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout: actual %0d samples outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic add_period(input int v, input logic dir);
    exp_t e;
    e.data = DW'(v);
    e.wrap = 1'b0;
    e.dir  = dir;
    period.push_back(e);
  endtask

  // One full period of the expected waveform; element 0 is the start value.
  task automatic build_period(input case_t c);
    int v;
    period.delete();
    case (c.mode)
      2'b00: for (v = c.lo; v <= c.hi; v += c.step) add_period(v, 1'b1);
      2'b11: for (v = c.hi; v >= c.lo; v -= c.step) add_period(v, 1'b0);
      2'b10: add_period(c.lo, 1'b1);
      default: begin
        for (v = c.lo; v < c.hi; v += c.step) add_period(v, 1'b1);
        add_period(c.hi, 1'b0);
        for (v = c.hi - c.step; v > c.lo; v -= c.step) add_period(v, 1'b0);
      end
    endcase
  endtask

  task automatic run_case(input case_t c);
    exp_t e;
    int   len;
    bus.mode         = c.mode;
    bus.step         = SW'(c.step);
    bus.lower_limit  = DW'(c.lo);
    bus.upper_limit  = DW'(c.hi);
    bus.sync_restart = 1'b1;
    bus.enable       = 1'b0;
    tick();
    bus.sync_restart = 1'b0;
    bus.enable       = 1'b1;
    build_period(c);
    len = period.size();
    for (int k = 0; k < c.n; k++) begin
      e      = period[k % len];
      e.wrap = (c.mode != 2'b10) && (k >= len) && ((k % len) == 0);
      sb.push_back(e);
    end
    drain(c.n + 10);
    bus.enable = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_data"},  int'(bus.data_out),   0);
    check_val({tag, "_valid"}, int'(bus.data_valid), 0);
    check_val({tag, "_dir"},   int'(bus.direction),  1);
    check_val({tag, "_wrap"},  int'(bus.wrap_pulse), 0);
    check_val({tag, "_err"},   int'(bus.cfg_error),  0);
  endtask

  initial begin
    //          mode   step lo   hi   samples
    cases[0] = '{2'b01, 1,   0,   127, 260};
    cases[1] = '{2'b00, 7,   10,  100, 16};
    cases[2] = '{2'b11, 6,   0,   20,  10};
    cases[3] = '{2'b10, 3,   5,   60,  4};
    cases[4] = '{2'b01, 10,  3,   50,  14};
    cases[5] = '{2'b00, 127, 0,   127, 5};

    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.sync_restart = 1'b0;
    bus.mode         = 2'b00;
    bus.step         = SW'(1);
    bus.lower_limit  = '0;
    bus.upper_limit  = DW'(127);
    @(posedge clk);
    #2;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_case(cases[i]);

    // Enable gap at value 40, then synchronous restart.
    bus.mode         = 2'b00;
    bus.step         = SW'(1);
    bus.lower_limit  = '0;
    bus.upper_limit  = DW'(127);
    bus.sync_restart = 1'b1;
    tick();
    bus.sync_restart = 1'b0;
    bus.enable       = 1'b1;
    for (int v = 0; v <= 40; v++) push(v, 1'b0, 1'b1);
    drain(60);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("gap_valid", int'(bus.data_valid), 0);
      check_val("gap_hold",  int'(bus.data_out),   40);
    end
    bus.enable = 1'b1;
    push(41, 1'b0, 1'b1);
    drain(2);
    bus.sync_restart = 1'b1;
    tick();
    check_val("restart_valid", int'(bus.data_valid), 0);
    check_val("restart_data",  int'(bus.data_out),   41);
    bus.sync_restart = 1'b0;
    push(0, 1'b0, 1'b1);
    drain(3);

    // Zero step repeats the sample.
    push(1, 1'b0, 1'b1);
    drain(2);
    bus.step = '0;
    push(1, 1'b0, 1'b1);
    push(1, 1'b0, 1'b1);
    drain(3);
    bus.step = SW'(1);
    push(2, 1'b0, 1'b1);
    drain(2);

    // Inverted limits freeze the ramp; restoring them resumes.
    bus.lower_limit = DW'(50);
    bus.upper_limit = DW'(30);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("cfg_err_set",   int'(bus.cfg_error),  1);
      check_val("cfg_err_valid", int'(bus.data_valid), 0);
      check_val("cfg_err_hold",  int'(bus.data_out),   2);
    end
    bus.lower_limit = '0;
    bus.upper_limit = DW'(127);
    push(3, 1'b0, 1'b1);
    drain(1);
    check_val("cfg_err_clear", int'(bus.cfg_error), 0);

    // Upper limit pulled below the current sample wraps to lower.
    push(4, 1'b0, 1'b1);
    push(5, 1'b0, 1'b1);
    drain(3);
    bus.upper_limit = DW'(2);
    push(0, 1'b1, 1'b1);
    drain(2);
    bus.upper_limit = DW'(127);
    push(1, 1'b0, 1'b1);
    drain(2);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    #2;
    reset = 1'b0;
    push(0, 1'b0, 1'b1);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
